cfg_chain_loader: RTL and testbench

- Upstream driver of the fabric configuration chain.
- Accepts bitstream bytes over a valid/ready stream and serialises them into the `cfg_clk`/`cfg_value` pair that feeds the first cell's `cfg_bit` chain.
- Generates a glitch-free, register-driven `cfg_clk` at a programmable divided rate and reports completion.
- Optionally checks a trailing CRC-8 byte.

---
 rtl/cfg_loader_pkg.sv | 27 ++
 rtl/cfg_chain_loader_crc8.sv | 32 +++
 rtl/cfg_chain_loader.sv | 199 +++++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// ============================================================================
// Module  : cfg_loader_pkg
// Brief   : Shared state encoding and constants for the config-chain loader.
//           CRC_FETCH exists only when CFG_LOADER_CRC_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_loader_pkg;

    localparam int         BYTE_W    = 8;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_SHIFT_LOW  = 3'd2,
        ST_SHIFT_HIGH = 3'd3,
`ifdef CFG_LOADER_CRC_EN
        ST_CRC_FETCH  = 3'd5,
`endif
        ST_DONE       = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cfg_chain_loader_crc8.sv
// ============================================================================
// Module  : crc8_byte
// Brief   : Combinational CRC-8 update over one byte, MSB first.
//           Elaborated only when CFG_LOADER_CRC_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef CFG_LOADER_CRC_EN
module crc8_byte
    import cfg_loader_pkg::*;
(
    input  logic [BYTE_W-1:0] crc_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] crc_o
);

    logic [BYTE_W-1:0] w_crc;

    always_comb begin
        w_crc = crc_i ^ data_i;
        for (int i = 0; i < BYTE_W; i++) begin
            w_crc = w_crc[BYTE_W-1] ? ({w_crc[BYTE_W-2:0], 1'b0} ^ CRC8_POLY)
                                    :  {w_crc[BYTE_W-2:0], 1'b0};
        end
        crc_o = w_crc;
    end

endmodule
`endif

`default_nettype wire

// File: rtl/cfg_chain_loader.sv
// ============================================================================
// Module  : cfg_chain_loader
// Brief   : Serialises bitstream bytes onto the cfg_clk/cfg_value chain pair.
//           Macro CFG_LOADER_CRC_EN adds a trailing CRC-8 byte check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 80,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_clk,
    output logic              cfg_value,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef CFG_LOADER_CRC_EN
    localparam state_e ST_AFTER_LAST = ST_CRC_FETCH;
`else
    localparam state_e ST_AFTER_LAST = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              cfg_clk_q, cfg_clk_d;
    logic              cfg_value_q, cfg_value_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_xfer;
    logic              w_div_end;

    assign w_xfer    = in_valid && in_ready_q;
    assign w_div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            cfg_clk_q   <= 1'b0;
            cfg_value_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_q      <= byte_d;
            cfg_clk_q   <= cfg_clk_d;
            cfg_value_q <= cfg_value_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            ST_FETCH: begin
                if (w_xfer) begin
                    byte_d  = in_data;
                    div_d   = '0;
                    state_d = ST_SHIFT_LOW;
                end
            end
            ST_SHIFT_LOW: begin
                if (w_div_end) begin
                    div_d   = '0;
                    state_d = ST_SHIFT_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT_HIGH: begin
                if (w_div_end) begin
                    div_d     = '0;
                    byte_d    = {1'b0, byte_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_AFTER_LAST;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_SHIFT_LOW;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`ifdef CFG_LOADER_CRC_EN
            ST_CRC_FETCH: begin
                if (w_xfer) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each port comes straight off a flop.
    always_comb begin
        cfg_clk_d   = (state_d == ST_SHIFT_HIGH);
        in_ready_d  = (state_d == ST_FETCH);
`ifdef CFG_LOADER_CRC_EN
        in_ready_d  = in_ready_d || (state_d == ST_CRC_FETCH);
`endif
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        cfg_value_d = cfg_value_q;
        if ((state_d == ST_SHIFT_LOW) && (state_q != ST_SHIFT_LOW)) begin
            cfg_value_d = byte_d[0];
        end
    end

`ifdef CFG_LOADER_CRC_EN
    logic [BYTE_W-1:0] crc_q, crc_d, w_crc_next;
    logic              crc_err_q, crc_err_d;

    crc8_byte u_crc8 (
        .crc_i  (crc_q),
        .data_i (in_data),
        .crc_o  (w_crc_next)
    );

    always_comb begin
        crc_d     = crc_q;
        crc_err_d = crc_err_q;
        if ((state_q == ST_IDLE) && start) begin
            crc_d     = '0;
            crc_err_d = 1'b0;
        end else if ((state_q == ST_FETCH) && w_xfer) begin
            crc_d = w_crc_next;
        end else if ((state_q == ST_CRC_FETCH) && w_xfer) begin
            crc_err_d = (in_data != crc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q     <= '0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign cfg_clk   = cfg_clk_q;
    assign cfg_value = cfg_value_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_chain_loader.sv
// ============================================================================
// Module  : tb_cfg_chain_loader
// Brief   : Self-checking bench for cfg_chain_loader (12-bit and 5-bit chains).
//           Follows CFG_LOADER_CRC_EN to include the trailing CRC byte.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_chain_loader;

    localparam int DIV = 2;
    localparam int NA  = 12;
    localparam int NB  = 5;
`ifdef CFG_LOADER_CRC_EN
    localparam int CRC_EN = 1;
`else
    localparam int CRC_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       sel = 1'b0;
    int         cyc = 0;

    logic a_start, a_valid, a_ready, a_cclk, a_cval, a_busy, a_done, a_err;
    logic b_start, b_valid, b_ready, b_cclk, b_cval, b_busy, b_done, b_err;
    logic m_ready, m_cclk, m_cval, m_busy, m_done, m_err;

    assign a_start = start & ~sel;
    assign a_valid = in_valid & ~sel;
    assign b_start = start & sel;
    assign b_valid = in_valid & sel;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_cclk  = sel ? b_cclk  : a_cclk;
    assign m_cval  = sel ? b_cval  : a_cval;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;

    cfg_chain_loader #(.CHAIN_LEN(NA), .CLK_DIV(DIV)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_data(in_data), .in_valid(a_valid),
        .in_ready(a_ready), .cfg_clk(a_cclk), .cfg_value(a_cval), .busy(a_busy),
        .done(a_done), .crc_err(a_err)
    );

    cfg_chain_loader #(.CHAIN_LEN(NB), .CLK_DIV(DIV)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_data(in_data), .in_valid(b_valid),
        .in_ready(b_ready), .cfg_clk(b_cclk), .cfg_value(b_cval), .busy(b_busy),
        .done(b_done), .crc_err(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC-8 as the remainder of (crc ^ byte) * x^8 modulo x^8+x^2+x+1.
    function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
        logic [15:0] r;
        r = {crc ^ b, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    logic [7:0]  ld_bytes [4];
    int          ld_delay [4];
    int          ld_nb;
    int          cur_n;
    logic [15:0] exp_bits;
    int          exp_lat;
    logic        exp_err;
    string       ld_name;
    logic [4:0]  last_chain;

    task automatic run_load();
        int          t0, k, wait_c, hs, run_hi, stable, viol, nbits, lat;
        logic [15:0] got_bits, mask;
        logic        prev_clk, prev_val, prev_hs, seen_done, got_err;
        logic [4:0]  chain;
        k = 0; wait_c = 0; hs = 0; run_hi = 0; stable = 1; viol = 0; nbits = 0;
        lat = -1; got_bits = '0; seen_done = 1'b0; got_err = 1'b0; chain = '0;
        mask = 16'((32'd1 << cur_n) - 1);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check({ld_name, " ready/busy at t0+1"}, 32'({m_ready, m_busy}), 32'h3);
        check({ld_name, " crc_err cleared by start"}, 32'(m_err), 32'h0);
        prev_clk = m_cclk;
        prev_val = m_cval;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            prev_hs = 1'b0;
            if (m_ready) begin
                if (wait_c < ld_delay[k]) begin
                    in_valid = 1'b0;
                    wait_c++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = ld_bytes[k];
                    prev_hs  = 1'b1;
                    hs++;
                    if (k < 3) k++;
                    wait_c = 0;
                end
            end else begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = 8'($urandom);
                start    = m_busy ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            @(negedge clk);
            if ((m_cval !== prev_val) && !(prev_clk && !m_cclk) && !prev_hs) viol++;
            if (m_cclk && !prev_clk) begin
                if (stable < DIV) viol++;
                if (nbits < 16) got_bits[nbits] = m_cval;
                nbits++;
                chain  = {chain[3:0], m_cval};
                run_hi = 1;
            end else if (m_cclk) begin
                run_hi++;
            end
            if (!m_cclk && prev_clk && run_hi != DIV) viol++;
            if (!m_cclk) stable = ((m_cval === prev_val) && !prev_clk) ? stable + 1 : 1;
            else         stable = 0;
            if (m_done) begin
                seen_done = 1'b1;
                lat       = cyc - t0;
                got_err   = m_err;
            end
            prev_clk = m_cclk;
            prev_val = m_cval;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        last_chain = chain;
        check({ld_name, " done latency"}, 32'(lat), 32'(exp_lat));
        check({ld_name, " bit count"}, 32'(nbits), 32'(cur_n));
        check({ld_name, " bit sequence"}, 32'(got_bits & mask), 32'(exp_bits & mask));
        check({ld_name, " handshakes"}, 32'(hs), 32'(ld_nb));
        check({ld_name, " chain timing violations"}, 32'(viol), 32'h0);
        check({ld_name, " crc_err at done"}, 32'(got_err), 32'(exp_err));
        @(negedge clk);
        check({ld_name, " done single cycle"}, 32'({m_done, m_busy}), 32'h0);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          d0;
        int          d1;
        logic [11:0] bits;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    task automatic setup_a(input logic [7:0] b0, input logic [7:0] b1, input int d0,
                           input int d1, input int dcrc, input logic corrupt);
        logic [7:0] crc;
        ld_bytes[0] = b0;  ld_bytes[1] = b1;
        ld_delay[0] = d0;  ld_delay[1] = d1;
        ld_delay[2] = dcrc; ld_delay[3] = 0;
        crc = crc_step(crc_step(8'h00, b0), b1);
        ld_bytes[2] = corrupt ? (crc ^ 8'h01) : crc;
        ld_bytes[3] = 8'h00;
        ld_nb   = 2 + CRC_EN;
        cur_n   = NA;
        exp_err = (CRC_EN != 0) && corrupt;
    endtask

    initial begin
        int c;
        vecs[0] = '{8'hA5, 8'h0F, 0,  0, 12'hFA5, 51};
        vecs[1] = '{8'hA5, 8'h0F, 10, 0, 12'hFA5, 61};
        vecs[2] = '{8'h00, 8'h00, 0,  2, 12'h000, 53};
        vecs[3] = '{8'hFF, 8'hFF, 3,  1, 12'hFFF, 55};
        vecs[4] = '{8'h5A, 8'hF0, 1,  0, 12'h05A, 52};
        vecs[5] = '{8'h3C, 8'hA7, 0,  5, 12'h73C, 56};

        repeat (3) @(negedge clk);
        check("reset outputs A", 32'({a_ready, a_cclk, a_cval, a_busy, a_done, a_err}), 32'h0);
        check("reset outputs B", 32'({b_ready, b_cclk, b_cval, b_busy, b_done, b_err}), 32'h0);
        rst_n = 1'b1;

        // Reset during SHIFT_HIGH on the 12-bit chain.
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!m_cclk && c < 100) begin
            in_valid = m_ready;
            in_data  = 8'hFF;
            @(negedge clk);
            c++;
        end
        check("reach shift_high before reset", 32'(m_cclk), 32'h1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("outputs after mid-load reset", 32'({m_cclk, m_cval, m_busy, m_ready}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            setup_a(vecs[i].b0, vecs[i].b1, vecs[i].d0, vecs[i].d1, 0, 1'b0);
            exp_bits = {4'h0, vecs[i].bits};
            exp_lat  = vecs[i].lat + CRC_EN;
            ld_name  = $sformatf("vec%0d", i);
            run_load();
        end

        for (int r = 0; r < 8; r++) begin
            int dc;
            dc = int'($urandom_range(2, 0));
            setup_a(8'($urandom), 8'($urandom), int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)), dc, 1'($urandom_range(3, 0) == 0));
            exp_bits = '0;
            for (int i = 0; i < NA; i++) exp_bits[i] = ld_bytes[i / 8][i % 8];
            exp_lat = 1 + 2 + ld_delay[0] + ld_delay[1] + 2 * DIV * NA + CRC_EN * (1 + dc);
            ld_name = $sformatf("rand%0d", r);
            run_load();
        end

        // Single 5-bit cell.
        sel = 1'b1;
        ld_bytes[0] = 8'h1B; ld_bytes[1] = 8'h41; ld_bytes[2] = 8'h00; ld_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) ld_delay[i] = 0;
        ld_nb    = 1 + CRC_EN;
        cur_n    = NB;
        exp_bits = 16'h001B;
        exp_lat  = 22 + CRC_EN;
        exp_err  = 1'b0;
        ld_name  = "cell";
        run_load();
        check("cell register,on11,on10,on01,on00", 32'(last_chain), 32'h1B);

`ifdef CFG_LOADER_CRC_EN
        ld_bytes[1] = 8'h40;
        exp_err     = 1'b1;
        ld_name     = "cell bad crc";
        run_load();
        repeat (5) @(negedge clk);
        check("crc_err held in idle", 32'(m_err), 32'h1);
        ld_bytes[1] = 8'h41;
        exp_err     = 1'b0;
        ld_name     = "cell after bad crc";
        run_load();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
